// File: rtl/cpu_loader_if.sv
// cpu_loader_if
//   Groups the loader's UART byte streams, program-RAM ports and CPU control
//   lines into one bundle.
//   master : the loader side (drives tx, RAM write/read port and CPU control)
//   slave  : the environment side (UART rx/tx, RAM, CPU)
// Ports (signals):
//   rx_data/rx_valid          received byte + one-cycle strobe
//   tx_data/tx_valid/tx_ready reply byte handshake
//   mem_sel                   1 = loader owns RAM ports, 0 = CPU owns them
//   mem_waddr/mem_data_in/mem_write  RAM write port
//   mem_raddr/mem_data_out    RAM read port (read data 2 cycles after address)
//   cpu_reset/cpu_halt/cpu_start_address/cpu_halted  CPU control/status
interface cpu_loader_if #(
    parameter int ADDR_WIDTH = 9
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  mem_sel;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [7:0]            mem_data_in;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [7:0]            mem_data_out;
    logic                  cpu_reset;
    logic                  cpu_halt;
    logic [ADDR_WIDTH-1:0] cpu_start_address;
    logic                  cpu_halted;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_data_out, cpu_halted,
        output tx_data, tx_valid, mem_sel, mem_waddr, mem_data_in, mem_write,
               mem_raddr, cpu_reset, cpu_halt, cpu_start_address
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_data_out, cpu_halted,
        input  tx_data, tx_valid, mem_sel, mem_waddr, mem_data_in, mem_write,
               mem_raddr, cpu_reset, cpu_halt, cpu_start_address
    );
endinterface

// File: rtl/cpu_loader.sv
// cpu_loader
//   Host-side boot/monitor stage in front of the CPU. Decodes host commands
//   from the UART byte stream, writes program bytes into the shared program
//   RAM, starts/stops the CPU and replies with single status bytes.
//     'L' addr16 len16 data... : load bytes (stops CPU first)   -> 'K'
//     'R' addr16               : start CPU at addr              -> 'K'
//     'S'                      : stop CPU                       -> 'K'
//     'D' addr16 len16         : dump bytes (READBACK_EN only)  -> bytes, 'K'
//     other                    : -> '?'
//   CPU executing HALT while running -> 'H'.
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     cpu_loader_if.master (UART rx/tx, RAM ports, CPU control)
// Build option:
//   READBACK_EN  enables the 'D' dump command and the RAM read port; when
//                undefined mem_raddr is tied to 0 and 'D' replies '?'.
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_BOOT     | CPU held in reset for 2 cycles after reset release
// S_IDLE     | CPU stopped, waiting for a command byte
// S_ADDR_H   | waiting for address high byte
// S_ADDR_L   | waiting for address low byte
// S_LEN_H    | waiting for length high byte
// S_LEN_L    | waiting for length low byte
// S_DATA     | writing load data bytes into RAM
// S_STOPWAIT | cpu_halt asserted, waiting for cpu_halted
// S_START    | CPU reset pulse with new start address
// S_RUNNING  | CPU running, waiting for a command byte or HALT
// S_TX       | reply byte outstanding, returns to r_ret_state
// S_RD_ADDR  | dump: issue next read address or finish
// S_RD_WAIT  | dump: wait for RAM read latency
module cpu_loader #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic         clk,
    input  logic         resetn,
    cpu_loader_if.master bus
);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STOP = 8'h53;
`ifdef READBACK_EN
    localparam logic [7:0] CMD_DUMP = 8'h44;
`endif
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_HALT = 8'h48;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [3:0] {
        S_BOOT, S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA,
        S_STOPWAIT, S_START, S_RUNNING, S_TX, S_RD_ADDR, S_RD_WAIT
    } state_t;

    state_t                r_state;
    state_t                r_ret_state;
    logic [7:0]            r_cmd;
    logic [15:0]           r_addr;
    logic [15:0]           r_len;
    logic [1:0]            r_cnt;
    logic                  r_running;
    logic                  r_halted_q;
    logic                  r_cpu_reset;
    logic                  r_cpu_halt;
    logic                  r_mem_sel;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_waddr;
    logic [7:0]            r_mem_data_in;
    logic [ADDR_WIDTH-1:0] r_cpu_start_address;

    logic [15:0]           w_addr_full;
    logic [15:0]           w_len_full;
    state_t                w_body_state;

    assign w_addr_full = {r_addr[15:8], bus.rx_data};
    assign w_len_full  = {r_len[15:8], bus.rx_data};

`ifdef READBACK_EN
    logic [ADDR_WIDTH-1:0] r_mem_raddr;
    assign w_body_state  = (r_cmd == CMD_DUMP) ? S_RD_ADDR : S_DATA;
    assign bus.mem_raddr = r_mem_raddr;
`else
    logic w_unused_rdata;
    assign w_body_state   = S_DATA;
    assign bus.mem_raddr  = '0;
    assign w_unused_rdata = ^bus.mem_data_out;
`endif

    assign bus.cpu_reset         = r_cpu_reset;
    assign bus.cpu_halt          = r_cpu_halt;
    assign bus.cpu_start_address = r_cpu_start_address;
    assign bus.mem_sel           = r_mem_sel;
    assign bus.mem_waddr         = r_mem_waddr;
    assign bus.mem_data_in       = r_mem_data_in;
    assign bus.mem_write         = r_mem_write;
    assign bus.tx_data           = r_tx_data;
    assign bus.tx_valid          = r_tx_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state             <= S_BOOT;
            r_ret_state         <= S_IDLE;
            r_cmd               <= 8'h00;
            r_addr              <= 16'h0000;
            r_len               <= 16'h0000;
            r_cnt               <= 2'd1;
            r_running           <= 1'b0;
            r_halted_q          <= 1'b0;
            r_cpu_reset         <= 1'b1;
            r_cpu_halt          <= 1'b1;
            r_mem_sel           <= 1'b1;
            r_tx_data           <= 8'h00;
            r_tx_valid          <= 1'b0;
            r_mem_write         <= 1'b0;
            r_mem_waddr         <= '0;
            r_mem_data_in       <= 8'h00;
            r_cpu_start_address <= '0;
`ifdef READBACK_EN
            r_mem_raddr         <= '0;
`endif
        end else begin
            r_mem_write <= 1'b0;
            r_halted_q  <= bus.cpu_halted;
            case (r_state)
                S_BOOT: begin
                    if (r_cnt == 2'd0) begin
                        r_cpu_reset <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_IDLE, S_RUNNING: begin
                    // HALT executed by the CPU wins over a same-cycle byte
                    if (r_state == S_RUNNING && bus.cpu_halted && !r_halted_q) begin
                        r_cpu_halt  <= 1'b1;
                        r_mem_sel   <= 1'b1;
                        r_running   <= 1'b0;
                        r_tx_data   <= RSP_HALT;
                        r_tx_valid  <= 1'b1;
                        r_ret_state <= S_IDLE;
                        r_state     <= S_TX;
                    end else if (bus.rx_valid) begin
                        r_cmd <= bus.rx_data;
                        case (bus.rx_data)
                            CMD_LOAD, CMD_RUN: r_state <= S_ADDR_H;
`ifdef READBACK_EN
                            CMD_DUMP:          r_state <= S_ADDR_H;
`endif
                            CMD_STOP: begin
                                if (r_running) begin
                                    r_cpu_halt <= 1'b1;
                                    r_state    <= S_STOPWAIT;
                                end else begin
                                    r_tx_data   <= RSP_OK;
                                    r_tx_valid  <= 1'b1;
                                    r_ret_state <= S_IDLE;
                                    r_state     <= S_TX;
                                end
                            end
                            default: begin
                                r_tx_data   <= RSP_ERR;
                                r_tx_valid  <= 1'b1;
                                r_ret_state <= r_state;
                                r_state     <= S_TX;
                            end
                        endcase
                    end
                end
                S_ADDR_H: begin
                    if (bus.rx_valid) begin
                        r_addr[15:8] <= bus.rx_data;
                        r_state      <= S_ADDR_L;
                    end
                end
                S_ADDR_L: begin
                    if (bus.rx_valid) begin
                        r_addr <= w_addr_full;
                        if (r_cmd == CMD_RUN) begin
                            r_cpu_start_address <= w_addr_full[ADDR_WIDTH-1:0];
                            r_cpu_halt          <= 1'b0;
                            r_cpu_reset         <= 1'b1;
                            r_cnt               <= 2'd1;
                            r_state             <= S_START;
                        end else begin
                            r_state <= S_LEN_H;
                        end
                    end
                end
                S_LEN_H: begin
                    if (bus.rx_valid) begin
                        r_len[15:8] <= bus.rx_data;
                        r_state     <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (bus.rx_valid) begin
                        r_len <= w_len_full;
                        // empty transfer: acknowledge without touching the CPU
                        if (w_len_full == 16'd0) begin
                            r_tx_data   <= RSP_OK;
                            r_tx_valid  <= 1'b1;
                            r_ret_state <= r_running ? S_RUNNING : S_IDLE;
                            r_state     <= S_TX;
                        end else if (r_running) begin
                            r_cpu_halt <= 1'b1;
                            r_state    <= S_STOPWAIT;
                        end else begin
                            r_state <= w_body_state;
                        end
                    end
                end
                S_STOPWAIT: begin
                    if (bus.cpu_halted) begin
                        r_mem_sel <= 1'b1;
                        r_running <= 1'b0;
                        if (r_cmd == CMD_STOP) begin
                            r_tx_data   <= RSP_OK;
                            r_tx_valid  <= 1'b1;
                            r_ret_state <= S_IDLE;
                            r_state     <= S_TX;
                        end else begin
                            r_state <= w_body_state;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        r_mem_write   <= 1'b1;
                        r_mem_waddr   <= r_addr[ADDR_WIDTH-1:0];
                        r_mem_data_in <= bus.rx_data;
                        r_addr        <= r_addr + 16'd1;
                        r_len         <= r_len - 16'd1;
                        if (r_len == 16'd1) begin
                            r_tx_data   <= RSP_OK;
                            r_tx_valid  <= 1'b1;
                            r_ret_state <= S_IDLE;
                            r_state     <= S_TX;
                        end
                    end
                end
                S_START: begin
                    if (r_cnt == 2'd0) begin
                        r_cpu_reset <= 1'b0;
                        r_mem_sel   <= 1'b0;
                        r_running   <= 1'b1;
                        r_tx_data   <= RSP_OK;
                        r_tx_valid  <= 1'b1;
                        r_ret_state <= S_RUNNING;
                        r_state     <= S_TX;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_TX: begin
                    if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= r_ret_state;
                    end
                end
`ifdef READBACK_EN
                S_RD_ADDR: begin
                    if (r_len == 16'd0) begin
                        r_tx_data   <= RSP_OK;
                        r_tx_valid  <= 1'b1;
                        r_ret_state <= S_IDLE;
                        r_state     <= S_TX;
                    end else begin
                        r_mem_raddr <= r_addr[ADDR_WIDTH-1:0];
                        r_cnt       <= 2'd2;
                        r_state     <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // read data is valid two cycles after the address
                    if (r_cnt == 2'd0) begin
                        r_tx_data   <= bus.mem_data_out;
                        r_tx_valid  <= 1'b1;
                        r_addr      <= r_addr + 16'd1;
                        r_len       <= r_len - 16'd1;
                        r_ret_state <= S_RD_ADDR;
                        r_state     <= S_TX;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// tb_cpu_loader
//   Scoreboard bench for cpu_loader: expected RAM writes and reply bytes are
//   queued when a command is sent and compared when the DUT produces them.
//   A small CPU model answers cpu_halt/cpu_reset and can execute HALT after
//   a programmable number of cycles.
module tb_cpu_loader;

    localparam int AW = 9;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cpu_loader_if #(.ADDR_WIDTH(AW)) bus();

    cpu_loader #(.ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];

    // CPU model
    logic m_halted   = 1'b0;
    int   halt_after = 0;
    int   m_timer    = 0;
    assign bus.cpu_halted = m_halted;

    always @(posedge clk) begin
        if (bus.cpu_halt) begin
            m_halted <= 1'b1;
            m_timer  <= 0;
        end else if (bus.cpu_reset) begin
            m_halted <= 1'b0;
            m_timer  <= halt_after;
        end else if (m_timer == 1) begin
            m_halted <= 1'b1;
            m_timer  <= 0;
        end else if (m_timer > 1) begin
            m_timer <= m_timer - 1;
        end
    end

    // monitors
    logic       prev_pending = 1'b0;
    logic       prev_hs      = 1'b0;
    logic [7:0] prev_data    = 8'h00;
    int         rst_cnt      = 0;
    int         last_rst_w   = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_pending <= 1'b0;
            prev_hs      <= 1'b0;
            rst_cnt      <= 0;
        end else begin
            if (bus.mem_write) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", exp_wr.size(), 1);
                end else begin
                    check("wr_addr", bus.mem_waddr, exp_wr[0].addr);
                    check("wr_data", bus.mem_data_in, exp_wr[0].data);
                    check("wr_mem_sel", bus.mem_sel, 1);
                    check("wr_cpu_halted", m_halted, 1);
                    void'(exp_wr.pop_front());
                end
            end
            if (prev_pending) begin
                check("tx_hold_valid", bus.tx_valid, 1);
                check("tx_hold_data", bus.tx_data, prev_data);
            end
            if (prev_hs) check("tx_drop", bus.tx_valid, 0);
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", exp_tx.size(), 1);
                end else begin
                    check("tx_byte", bus.tx_data, exp_tx[0]);
                    void'(exp_tx.pop_front());
                end
            end
            prev_pending <= bus.tx_valid && !bus.tx_ready;
            prev_hs      <= bus.tx_valid && bus.tx_ready;
            prev_data    <= bus.tx_data;
            if (bus.cpu_reset) begin
                rst_cnt <= rst_cnt + 1;
            end else if (rst_cnt > 0) begin
                last_rst_w <= rst_cnt;
                rst_cnt    <= 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // byte gap mimics UART pacing and covers the STOPWAIT window
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_tx.size() == 0 && exp_wr.size() == 0) break;
            tick();
        end
        repeat (5) tick();
        check("drain", exp_tx.size() + exp_wr.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data      = 8'h00;
        bus.rx_valid     = 1'b0;
        bus.tx_ready     = 1'b1;
        bus.mem_data_out = 8'h00;
        resetn           = 1'b0;
        repeat (3) tick();
        check("rst_cpu_reset", bus.cpu_reset, 1);
        check("rst_cpu_halt", bus.cpu_halt, 1);
        check("rst_mem_sel", bus.mem_sel, 1);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_waddr", bus.mem_waddr, 0);
        check("rst_start_addr", bus.cpu_start_address, 0);
        resetn = 1'b1;
        tick();
        check("boot_reset_c1", bus.cpu_reset, 1);
        tick();
        check("boot_reset_c2", bus.cpu_reset, 0);
        check("boot_cpu_halt", bus.cpu_halt, 1);
        check("boot_mem_sel", bus.mem_sel, 1);
        tick();
        check("boot_cpu_parked", m_halted, 1);

        // load 3 bytes
        push_wr(9'h010, 8'hAA); push_wr(9'h011, 8'hBB); push_wr(9'h012, 8'hCC);
        exp_tx.push_back(8'h4B);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        drain(200);

        // zero length
        exp_tx.push_back(8'h4B);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        drain(200);

        // address wrap
        push_wr(9'h1FF, 8'h11); push_wr(9'h000, 8'h22);
        exp_tx.push_back(8'h4B);
        send_byte(8'h4C); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        drain(200);

        // run, CPU halts by itself
        halt_after = 50;
        exp_tx.push_back(8'h4B);
        exp_tx.push_back(8'h48);
        send_byte(8'h52); send_byte(8'h00);
        bus.rx_data  = 8'h10;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 40 && exp_tx.size() > 1; i++) tick();
        check("run_k_seen", exp_tx.size(), 1);
        check("run_start_addr", bus.cpu_start_address, 9'h010);
        check("run_reset_width", last_rst_w, 2);
        check("run_mem_sel", bus.mem_sel, 0);
        check("run_cpu_halt", bus.cpu_halt, 0);
        drain(300);
        check("halt_mem_sel", bus.mem_sel, 1);
        check("halt_cpu_halt", bus.cpu_halt, 1);
        check("halt_cpu_halted", m_halted, 1);

        // stop while running, then stop when already stopped
        halt_after = 0;
        exp_tx.push_back(8'h4B);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
        drain(200);
        check("run2_mem_sel", bus.mem_sel, 0);
        check("run2_start_addr", bus.cpu_start_address, 9'h020);
        exp_tx.push_back(8'h4B);
        send_byte(8'h53);
        drain(200);
        check("stop_cpu_halt", bus.cpu_halt, 1);
        check("stop_mem_sel", bus.mem_sel, 1);
        check("stop_cpu_halted", m_halted, 1);
        exp_tx.push_back(8'h4B);
        send_byte(8'h53);
        drain(200);

        // unknown byte while running keeps the CPU running
        exp_tx.push_back(8'h4B);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
        drain(200);
        exp_tx.push_back(8'h3F);
        send_byte(8'h7A);
        drain(200);
        check("unk_run_mem_sel", bus.mem_sel, 0);
        check("unk_run_cpu_halt", bus.cpu_halt, 0);

        // load while running: CPU stopped before the write, no 'H'
        push_wr(9'h000, 8'h55);
        exp_tx.push_back(8'h4B);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h55);
        drain(200);
        check("ldrun_cpu_halt", bus.cpu_halt, 1);

        // unknown commands
        exp_tx.push_back(8'h3F);
        send_byte(8'h7A);
        drain(200);
`ifndef READBACK_EN
        exp_tx.push_back(8'h3F);
        send_byte(8'h44);
        drain(200);
`endif

        // backpressure
        bus.tx_ready = 1'b0;
        exp_tx.push_back(8'h3F);
        send_byte(8'h7A);
        repeat (14) tick();
        check("bp_valid", bus.tx_valid, 1);
        check("bp_data", bus.tx_data, 8'h3F);
        check("bp_pending", exp_tx.size(), 1);
        bus.tx_ready = 1'b1;
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
